scmi_db_irq_arbiter: RTL and testbench

Doorbell interrupt arbiter between the external SCMI doorbell lines and the PMS core interrupt controller. It latches rising edges on up to 256 doorbell lines as pending channel requests. It then presents them to the core one at a time, in round-robin order, as a single interrupt plus channel ID. Each grant is held until the core acknowledges it and later signals that servicing is complete, so concurrent doorbells from many agents are never lost or merged.

---
 rtl/scmi_db_pkg.sv | 6 +
 rtl/scmi_db_rr_pick.sv | 19 +
 rtl/scmi_db_irq_arbiter.sv | 84 ++++++++
 tb/tb_scmi_db_irq_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/scmi_db_pkg.sv
// scmi_db_pkg: shared FSM state type and default sizing for the SCMI doorbell interrupt arbiter.
package scmi_db_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, SERVICE} scmi_db_state_e;
  localparam int SCMI_DB_NUM_CH = 256;
  localparam int SCMI_DB_TIMEOUT_CYCLES = 1024;
endpackage

// File: rtl/scmi_db_rr_pick.sv
// scmi_db_rr_pick: first set request at or above rr_ptr, wrapping around to bit 0.
module scmi_db_rr_pick #(
  parameter int NUM_CH = 256,
  parameter int IDW = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDW-1:0]    rr_ptr,
  output logic              valid,
  output logic [IDW-1:0]    id
);
  logic [NUM_CH-1:0] hi, src;
  always_comb begin
    hi = req & ({NUM_CH{1'b1}} << rr_ptr);
    src = (|hi) ? hi : req;
    valid = |req;
    id = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) if (src[i]) id = IDW'(i);
  end
endmodule

// File: rtl/scmi_db_irq_arbiter.sv
// scmi_db_irq_arbiter: latches doorbell edges and grants them round-robin, one at a time, to the core.
// Optional service watchdog is built when SCMI_DB_TIMEOUT_EN is defined.
module scmi_db_irq_arbiter
  import scmi_db_pkg::*;
#(
  parameter int NUM_CH = SCMI_DB_NUM_CH,
  parameter int IDW = $clog2(NUM_CH),
  parameter int TIMEOUT_CYCLES = SCMI_DB_TIMEOUT_CYCLES
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NUM_CH-1:0] db_irq_i,
  input  logic [NUM_CH-1:0] ch_en_i,
  output logic              irq_o,
  output logic [IDW-1:0]    irq_id_o,
  input  logic              irq_ack_i,
  input  logic              done_i,
  output logic [NUM_CH-1:0] pending_o,
  output logic              busy_o,
  output logic              overrun_o,
  input  logic              ovr_clr_i,
  output logic              timeout_o
);
  scmi_db_state_e state, state_n;
  logic [NUM_CH-1:0] db_q, pending, edge_v, clr_v, elig;
  logic [IDW-1:0] rr_ptr, pick_id, next_ptr;
  logic pick_valid, ack_fire, svc_end, tmo_hit;
  assign edge_v = db_irq_i & ~db_q & ch_en_i;
  assign elig = pending & ch_en_i;
  assign ack_fire = state == ISSUE && irq_ack_i;
  assign clr_v = ack_fire ? {{(NUM_CH-1){1'b0}}, 1'b1} << irq_id_o : '0;
  assign svc_end = state == SERVICE && (done_i || tmo_hit);
  assign next_ptr = (irq_id_o == IDW'(NUM_CH - 1)) ? '0 : irq_id_o + 1'b1;
  assign pending_o = pending;
  assign busy_o = state != IDLE;
  assign irq_o = state == ISSUE;
  scmi_db_rr_pick #(.NUM_CH(NUM_CH), .IDW(IDW)) u_pick (
    .req    (elig),
    .rr_ptr (rr_ptr),
    .valid  (pick_valid),
    .id     (pick_id)
  );
  always_comb begin
    state_n = state;
    state_n = state == IDLE  ? (pick_valid ? ISSUE : IDLE) :
              state == ISSUE ? (irq_ack_i ? SERVICE : ISSUE) :
                               (svc_end ? IDLE : SERVICE);
  end
  // New edges are OR-ed in after the ack clear so a same-cycle edge keeps the bit set
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      db_q <= '0;
      pending <= '0;
      overrun_o <= 1'b0;
      irq_id_o <= '0;
      rr_ptr <= '0;
    end else begin
      state <= state_n;
      db_q <= db_irq_i;
      pending <= (pending & ~clr_v) | edge_v;
      overrun_o <= (overrun_o & ~ovr_clr_i) | (|(edge_v & pending));
      if (state == IDLE && pick_valid) irq_id_o <= pick_id;
      if (svc_end) rr_ptr <= next_ptr;
    end
  end
`ifdef SCMI_DB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] tmo_cnt;
  assign tmo_hit = state == SERVICE && tmo_cnt == CW'(TIMEOUT_CYCLES - 1) && !done_i;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_cnt <= '0;
      timeout_o <= 1'b0;
    end else begin
      tmo_cnt <= ack_fire ? '0 : (state == SERVICE ? tmo_cnt + 1'b1 : tmo_cnt);
      timeout_o <= tmo_hit;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign timeout_o = 1'b0;
`endif
endmodule

// File: tb/tb_scmi_db_irq_arbiter.sv
// tb_scmi_db_irq_arbiter: randomized-order doorbell scenarios scored against a set-and-pointer arbitration model.
module tb_scmi_db_irq_arbiter;
  localparam int N = 256;
  logic clk = 1'b0, rst_ni = 1'b0;
  logic [N-1:0] db = '0, en = '1;
  logic ack = 1'b0, done = 1'b0, ovr_clr = 1'b0;
  logic irq, busy, ovr, tmo;
  logic [7:0] irq_id;
  logic [N-1:0] pend;
  bit [N-1:0] m_pend = '0, m_db = '0;
  bit m_ovr = 1'b0;
  int m_ptr = 0;
  int exp_q[$];
  int n_chk = 0, n_fail = 0;

  scmi_db_irq_arbiter #(.NUM_CH(N), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .db_irq_i(db), .ch_en_i(en),
    .irq_o(irq), .irq_id_o(irq_id), .irq_ack_i(ack), .done_i(done),
    .pending_o(pend), .busy_o(busy), .overrun_o(ovr), .ovr_clr_i(ovr_clr),
    .timeout_o(tmo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [N-1:0] bm(input int c);
    bm = '0;
    bm[c] = 1'b1;
  endfunction

  // Model: a set of pending channels; a new enabled rise on an already-pending channel is an overrun
  function automatic void model_cycle(input logic [N-1:0] dnew, input int clr);
    bit [N-1:0] r;
    r = dnew & ~m_db & en;
    if (|(r & m_pend)) m_ovr = 1'b1;
    if (clr >= 0) m_pend[clr] = 1'b0;
    m_pend |= r;
    m_db = dnew;
  endfunction

  function automatic int pick();
    for (int i = 0; i < N; i++) begin
      int c = (m_ptr + i) % N;
      if (m_pend[c] && en[c]) return c;
    end
    return -1;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_db(input logic [N-1:0] v);
    db = v;
    model_cycle(v, -1);
  endtask

  task automatic pulse(input logic [N-1:0] m);
    set_db(db | m);
    step(1);
    set_db(db & ~m);
    step(1);
  endtask

  task automatic wait_irq(output bit ok);
    for (int k = 0; k < 50; k++) begin
      if (irq) begin
        ok = 1'b1;
        return;
      end
      step(1);
    end
    ok = 1'b0;
    n_chk++;
    n_fail++;
    $display("FAIL wait_irq: got no irq in 50 cycles, expected a grant");
  endtask

  task automatic grant(input logic [N-1:0] m, output int e);
    bit ok;
    e = pick();
    wait_irq(ok);
    if (!ok) return;
    exp_q.push_back(e);
    ack = 1'b1;
    db = db | m;
    model_cycle(db, e);
    step(1);
    ack = 1'b0;
    set_db(db & ~m);
  endtask

  task automatic finish_svc(input int e);
    done = 1'b1;
    step(1);
    done = 1'b0;
    m_ptr = (e + 1) % N;
  endtask

  task automatic serve();
    int e;
    grant('0, e);
    finish_svc(e);
  endtask

  always @(negedge clk) begin : mon
    int e;
    if (rst_ni && irq && ack) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL grant_unexpected: got id %0d, expected no grant", irq_id);
      end else begin
        e = exp_q.pop_front();
        chk("grant_id", irq_id, e);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got no finish, expected end of test");
    $fatal(1);
  end

  initial begin
    int e, kk, hits;
    bit seen;
    logic [N-1:0] m, sh;
    #2;
    chk("rst_irq", irq, 0); chk("rst_id", irq_id, 0); chk("rst_pend", pend, 0);
    chk("rst_busy", busy, 0); chk("rst_ovr", ovr, 0); chk("rst_tmo", tmo, 0);
    step(2);
    rst_ni = 1'b1;
    step(1);
    pulse('1);
    for (int i = 0; i < N; i++) serve();
    step(2);
    chk("all_busy", busy, 0); chk("all_pend", pend, m_pend); chk("all_ovr", ovr, m_ovr);
    pulse(bm(5));
    wait_irq(seen);
    pulse(bm(5));
    grant(bm(5), e);
    chk("ch5_pend", pend[5], m_pend[5]); chk("ch5_ovr", ovr, m_ovr);
    finish_svc(e);
    serve();
    ovr_clr = 1'b1;
    step(1);
    ovr_clr = 1'b0;
    m_ovr = 1'b0;
    chk("ovr_clr", ovr, m_ovr);
    pulse(bm(200));
    serve();
    pulse(bm(3) | bm(200));
    serve();
    serve();
    en[7] = 1'b0;
    pulse(bm(7));
    step(3);
    chk("mask7_pend", pend[7], 0); chk("mask7_irq", irq, 0);
    en[7] = 1'b1;
    set_db(db | bm(9));
    step(1);
    set_db(db & ~bm(9));
    en[9] = 1'b0;
    step(5);
    chk("dis9_irq", irq, 0); chk("dis9_pend", pend[9], 1);
    en[9] = 1'b1;
    serve();
    // A burst of random distinct channels, served in model order
    m = '0;
    for (int i = 0; i < 12; i++) m[$urandom_range(N - 1, 0)] = 1'b1;
    pulse(m);
    for (int i = 0; i < $countones(m); i++) serve();
    pulse(bm(2) | bm(4));
    grant('0, e);
`ifdef SCMI_DB_TIMEOUT_EN
    seen = 1'b0;
    kk = 0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      step(1);
      if (tmo) begin
        seen = 1'b1;
        kk = k;
      end
    end
    chk("tmo_seen", seen, 1); chk("tmo_delay", kk, 16);
    m_ptr = (e + 1) % N;
    step(1);
    chk("tmo_width", tmo, 0);
    serve();
`else
    hits = 0;
    for (int k = 0; k < 40; k++) begin
      step(1);
      if (tmo) hits++;
    end
    chk("tmo_none", hits, 0); chk("svc_busy", busy, 1); chk("svc_irq", irq, 0);
    finish_svc(e);
    serve();
`endif
    sh = '0;
    for (int i = 20; i <= 30; i++) sh[i] = 1'b1;
    pulse(sh);
    grant('0, e);
    step(2);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_irq", irq, 0); chk("arst_id", irq_id, 0); chk("arst_pend", pend, 0);
    chk("arst_busy", busy, 0); chk("arst_ovr", ovr, 0); chk("arst_tmo", tmo, 0);
    m_pend = '0;
    m_ovr = 1'b0;
    m_ptr = 0;
    step(2);
    rst_ni = 1'b1;
    step(10);
    chk("post_irq", irq, 0); chk("post_busy", busy, 0); chk("post_pend", pend, m_pend);
    chk("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
